// File: rtl/sw_program_loader.sv
// ---------------------------------------------------------------------------
// sw_program_loader
//
// Front-panel program loader for the 16-bit CPU board. The user keys two
// 8-bit switch entries (high byte first) with a debounced push-button. The
// block assembles them into one 16-bit word and writes it to memory over a
// request/acknowledge port at an auto-incrementing address. The processor is
// held while load mode is enabled.
//
// Parameters
//   ADDR_W      memory address width; the address counter spans 0 .. 2^ADDR_W-1
//   START_ADDR  first address written after each load entry
//
// Ports
//   Clk         system clock
//   Reset       synchronous, active-high reset
//   Load_En     load-mode switch level (1 = loading)
//   Enter       debounced button level; its rising edge is detected here
//   Data_In     byte value from the switches
//   Mem_WrAck   memory accepts the current write in this cycle
//   Mem_WrReq   write request, held until acknowledged
//   Mem_Addr    write address (also shown on the display)
//   Mem_Data    assembled word {hi, lo}
//   Proc_Hold   stalls the processor while loading
//   Byte_Sel    0 = next Enter captures the high byte, 1 = the low byte
//   Full        last address has been written
//   Word_Count  words written since entering load mode
// ---------------------------------------------------------------------------
module sw_program_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_En,
  input  logic              Enter,
  input  logic [7:0]        Data_In,
  input  logic              Mem_WrAck,
  output logic              Mem_WrReq,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_Data,
  output logic              Proc_Hold,
  output logic              Byte_Sel,
  output logic              Full,
  output logic [ADDR_W:0]   Word_Count
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = START_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_FULL
  } state_t;

  state_t              state;
  state_t              nxt;
  logic                enter_q;
  logic                enter_edge;
  logic [15:0]         word;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     count;

  assign enter_edge = Enter & ~enter_q;

  // Leaving load mode takes priority over a simultaneous Enter edge, so a
  // partial word is discarded rather than advanced. A pending write is never
  // abandoned: WRITE only exits on acknowledge.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (Load_En) nxt = S_HI;
      S_HI: begin
        if (!Load_En)        nxt = S_IDLE;
        else if (enter_edge) nxt = S_LO;
      end
      S_LO: begin
        if (!Load_En)        nxt = S_IDLE;
        else if (enter_edge) nxt = S_WRITE;
      end
      S_WRITE: begin
        if (Mem_WrAck) begin
          if (!Load_En)               nxt = S_IDLE;
          else if (addr == LAST_ADDR) nxt = S_FULL;
          else                        nxt = S_HI;
        end
      end
      S_FULL:  if (!Load_En) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      enter_q    <= 1'b1;  // a button held through reset yields no edge
      word       <= '0;
      addr       <= FIRST_ADDR;
      count      <= '0;
      Mem_WrReq  <= 1'b0;
      Proc_Hold  <= 1'b0;
      Byte_Sel   <= 1'b0;
      Full       <= 1'b0;
    end else begin
      enter_q    <= Enter;
      state      <= nxt;
      Mem_WrReq  <= (nxt == S_WRITE);
      Proc_Hold  <= (nxt != S_IDLE);
      Byte_Sel   <= (nxt == S_LO);
      Full       <= (nxt == S_FULL);

      case (state)
        S_IDLE: begin
          // Counters restart only on load entry so the last values stay
          // visible on the display while idle.
          if (Load_En) begin
            addr  <= FIRST_ADDR;
            count <= '0;
          end
        end
        S_HI: if (Load_En && enter_edge) word[15:8] <= Data_In;
        S_LO: if (Load_En && enter_edge) word[7:0]  <= Data_In;
        S_WRITE: begin
          if (Mem_WrAck) begin
            addr  <= addr + 1'b1;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Mem_Addr   = addr;
  assign Mem_Data   = word;
  assign Word_Count = count;

endmodule

// File: doc/sw_program_loader.md
# sw_program_loader

Front-panel program loader for the 16-bit CPU board: the user keys instruction words into the processor's memory through the switches and a debounced push-button, the input-side counterpart of the hex display readout. Assembles two 8-bit switch entries (high byte first) into one 16-bit word, writes it to memory over a request/acknowledge port at an auto-incrementing address, and holds the processor while loading is enabled. Sits between the KeyFilter output and the processor's memory write port in the top level.

## Interface
- ADDR_W, 8, memory address width; the address counter spans 0 .. 2^ADDR_W-1
- START_ADDR, 0, first address written after each load entry
- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge
- Load_En  in  1  load-mode switch level (SW[17]); 1 = loading
- Enter  in  1  debounced, active-high button level; the block detects its rising edge internally
- Data_In  in  8  byte value from SW[7:0]
- Mem_WrAck  in  1  memory accepts the current write in this cycle
- Mem_WrReq  out  1  write request
- Mem_Addr  out  ADDR_W  write address (also drives the display)
- Mem_Data  out  16  assembled word {hi, lo}
- Proc_Hold  out  1  stalls the processor while loading
- Byte_Sel  out  1  0 = next Enter captures the high byte, 1 = the low byte
- Full  out  1  last address has been written
- Word_Count  out  ADDR_W+1  words written since entering load mode

## Operation
- States: IDLE, HI, LO, WRITE, FULL.
- Reset value of all outputs is 0, and the state is IDLE. Reset also sets the edge register Enter_q to 1, so a button held during reset produces no edge. Word register = 0, Addr = START_ADDR.
- Enter edge = Enter & ~Enter_q. Enter_q <= Enter every cycle.
- IDLE: Proc_Hold=0. If Load_En=1 → HI. Addr <= START_ADDR, Word_Count <= 0, Full <= 0.
- HI: on an Enter edge, Word[15:8] <= Data_In → LO.
- LO: on an Enter edge, Word[7:0] <= Data_In → WRITE.
- WRITE: Mem_WrReq=1. Mem_Addr and Mem_Data stay stable until Mem_WrAck. On ack: Addr <= Addr+1 and Word_Count <= Word_Count+1.
  - If Addr was 2^ADDR_W-1 → FULL (Addr wraps to 0 but is not used; Full <= 1).
  - Otherwise → HI.
- FULL: Full=1; Enter edges are ignored.
- Proc_Hold=1 in HI, LO, WRITE and FULL.
- Byte_Sel=1 only in LO.
- Load_En=0 in HI, LO or FULL → IDLE next cycle. A partially entered word is discarded, and Word_Count/Mem_Addr keep their last values for display.
- Load_En=0 in WRITE: the request is never abandoned. The request holds until ack, the write counts, then → IDLE (not HI/FULL).
- Enter edges during WRITE or IDLE are dropped; they are not queued.
- Mem_Data is driven from the Word register at all times. Mem_Addr is driven from Addr.
- Reset mid-operation (any state, including WRITE with the request pending) → IDLE next cycle, with Mem_WrReq deasserted immediately at that edge.

## Timing
- Enter edge detected in cycle n (Enter=1, Enter_q=0) → the byte is captured and the state advances at the end of cycle n; new Byte_Sel is visible in cycle n+1.
- Low-byte capture in cycle n → Mem_WrReq=1 from cycle n+1.
- Mem_WrAck in the same cycle as Mem_WrReq is legal. The request is then high for exactly 1 cycle, and the next state (HI/FULL/IDLE) begins in the following cycle.
- Minimum per word: 2 Enter edges + 1 WRITE cycle.
- Mem_WrAck outside WRITE is ignored.
- Load_En is registered directly by the state transition; there is 1 cycle of latency from a Load_En change to a Proc_Hold change.

## Test plan
- Reset with Enter held high, then Load_En=1, then release and press Enter with Data_In=0x12 → only one capture occurs: Word[15:8]=0x12, Byte_Sel=1, Proc_Hold=1.
- Enter 0x12 then 0x34, with Mem_WrAck tied high → one Mem_WrReq pulse with Mem_Addr=0x00 and Mem_Data=0x1234; then Mem_Addr=0x01, Word_Count=1, state HI.
- Same entry, with ack delayed 5 cycles → Mem_WrReq high for 6 cycles, Addr/Data stable throughout, extra Enter presses ignored, exactly one write.
- ADDR_W=2, write 4 words → Full=1 after the 4th ack, Word_Count=4, further Enter presses produce no request; Load_En=0 → IDLE, Proc_Hold=0, Full=0 on next entry.
- Load_En dropped after the high byte only → IDLE, no write; dropped during a pending WRITE → write completes on ack, then IDLE.
- Reset asserted while Mem_WrReq=1 → all outputs 0 the next cycle, state IDLE, no ack is counted.
